// File: rtl/display_timing_pkg.sv
// Shared raster types and 800x600@72 Hz timing constants
// for the display timing controller.
package display_timing_pkg;

    typedef enum logic [1:0] {ACT, FP, SYNC, BP} axis_state_t;

    typedef logic [10:0] coord_t;

    localparam int unsigned SVGA72_H_ACTIVE = 800;
    localparam int unsigned SVGA72_H_FP     = 56;
    localparam int unsigned SVGA72_H_SYNC   = 120;
    localparam int unsigned SVGA72_H_BP     = 64;
    localparam int unsigned SVGA72_V_ACTIVE = 600;
    localparam int unsigned SVGA72_V_FP     = 37;
    localparam int unsigned SVGA72_V_SYNC   = 6;
    localparam int unsigned SVGA72_V_BP     = 23;

    function automatic int unsigned axis_total(
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned SVGA72_H_TOTAL = axis_total(
        SVGA72_H_ACTIVE, SVGA72_H_FP, SVGA72_H_SYNC, SVGA72_H_BP);
    localparam int unsigned SVGA72_V_TOTAL = axis_total(
        SVGA72_V_ACTIVE, SVGA72_V_FP, SVGA72_V_SYNC, SVGA72_V_BP);

endpackage

// File: rtl/display_timing_controller_timing_axis.sv
// One raster axis: position counter plus its porch/sync region FSM,
// advancing only on cycles where step is high.
module timing_axis
    import display_timing_pkg::*;
#(
    parameter int unsigned N_ACTIVE = 800,
    parameter int unsigned N_FP     = 56,
    parameter int unsigned N_SYNC   = 120,
    parameter int unsigned N_BP     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output coord_t      cnt,
    output axis_state_t state,
    output logic        wrap
);

    localparam coord_t END_ACT  = coord_t'(N_ACTIVE - 1);
    localparam coord_t END_FP   = coord_t'(N_ACTIVE + N_FP - 1);
    localparam coord_t END_SYNC = coord_t'(N_ACTIVE + N_FP + N_SYNC - 1);
    localparam coord_t END_BP   =
        coord_t'(axis_total(N_ACTIVE, N_FP, N_SYNC, N_BP) - 1);

    axis_state_t state_d;

    assign wrap = step && (cnt == END_BP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + coord_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (step) begin
            unique case (state)
                ACT:  if (cnt == END_ACT)  state_d = FP;
                FP:   if (cnt == END_FP)   state_d = SYNC;
                SYNC: if (cnt == END_SYNC) state_d = BP;
                BP:   if (cnt == END_BP)   state_d = ACT;
            endcase
        end
    end

endmodule

// File: rtl/display_timing_controller.sv
// Raster sequencer: sync/de/coordinate generation plus one line
// prefetch per active line with late-prefetch (underrun) detection.
module display_timing_controller
    import display_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = SVGA72_H_ACTIVE,
    parameter int unsigned H_FP      = SVGA72_H_FP,
    parameter int unsigned H_SYNC    = SVGA72_H_SYNC,
    parameter int unsigned H_BP      = SVGA72_H_BP,
    parameter int unsigned V_ACTIVE  = SVGA72_V_ACTIVE,
    parameter int unsigned V_FP      = SVGA72_V_FP,
    parameter int unsigned V_SYNC    = SVGA72_V_SYNC,
    parameter int unsigned V_BP      = SVGA72_V_BP,
    parameter logic        HSYNC_POL = 1'b1,
    parameter logic        VSYNC_POL = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output logic   hsync,
    output logic   vsync,
    output logic   de,
    output coord_t x,
    output coord_t y,
    output logic   line_tc,
    output logic   frame_start,
    output logic   fetch_req,
    output coord_t fetch_line,
    input  logic   fetch_ack,
    output logic   underrun,
    input  logic   clr_underrun
);

    localparam coord_t H_FETCH = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_N = coord_t'(V_ACTIVE);
    localparam coord_t V_LAST  =
        coord_t'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);

    coord_t      hcnt;
    coord_t      vcnt;
    axis_state_t hstate;
    axis_state_t vstate;
    logic        h_wrap;
    logic        v_wrap;
    logic        at_origin;

    coord_t      v_next;
    coord_t      next_line;
    logic        line_due;
    logic        fetch_trig;
    logic        deadline;

    timing_axis #(
        .N_ACTIVE (H_ACTIVE),
        .N_FP     (H_FP),
        .N_SYNC   (H_SYNC),
        .N_BP     (H_BP)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (en),
        .cnt   (hcnt),
        .state (hstate),
        .wrap  (h_wrap)
    );

    timing_axis #(
        .N_ACTIVE (V_ACTIVE),
        .N_FP     (V_FP),
        .N_SYNC   (V_SYNC),
        .N_BP     (V_BP)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (h_wrap),
        .cnt   (vcnt),
        .state (vstate),
        .wrap  (v_wrap)
    );

    // Fetch events fire with the presented pixel, so fetch_req rises
    // alongside x=H_ACTIVE and the deadline lands with the new line's x=0.
    always_comb begin
        v_next     = vcnt + coord_t'(1);
        line_due   = (v_next < V_ACT_N) || (vcnt == V_LAST);
        next_line  = (vcnt == V_LAST) ? '0 : v_next;
        fetch_trig = en && (hcnt == H_FETCH) && line_due;
        deadline   = en && (hcnt == '0) && (vstate == ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_tc     <= 1'b0;
            frame_start <= 1'b0;
            at_origin   <= 1'b1;
        end else begin
            line_tc     <= h_wrap;
            frame_start <= en && at_origin;
            if (en) begin
                x         <= hcnt;
                y         <= vcnt;
                de        <= (hstate == ACT) && (vstate == ACT);
                hsync     <= (hstate == SYNC) ? HSYNC_POL : ~HSYNC_POL;
                vsync     <= (vstate == SYNC) ? VSYNC_POL : ~VSYNC_POL;
                at_origin <= v_wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_req  <= 1'b0;
            fetch_line <= '0;
        end else if (fetch_trig) begin
            fetch_req  <= 1'b1;
            fetch_line <= next_line;
        end else if (fetch_req && (fetch_ack || deadline)) begin
            fetch_req  <= 1'b0;
        end
    end

    // An ack on the deadline cycle still counts as on time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (fetch_req && deadline && !fetch_ack) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_timing_controller.sv
// Directed bench for display_timing_controller; full horizontal timing,
// shortened vertical timing (12/3/2/3 lines) to keep frames short.
module tb_display_timing_controller;

    localparam int HT  = 1040;
    localparam int VA  = 12;
    localparam int VT  = 20;
    localparam int HS0 = 856;
    localparam int HS1 = 975;
    localparam int VS0 = 15;
    localparam int VS1 = 16;

    logic        clk;
    logic        rst;
    logic        en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        line_tc;
    logic        frame_start;
    logic        fetch_req;
    logic [10:0] fetch_line;
    logic        fetch_ack;
    logic        underrun;
    logic        clr_underrun;

    logic        auto_en;
    logic        auto_ack;
    logic        man_ack;
    int          ack_cnt;
    int          checks;
    int          errors;

    assign fetch_ack = auto_ack | man_ack;

    display_timing_controller #(
        .V_ACTIVE (12),
        .V_FP     (3),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .x            (x),
        .y            (y),
        .line_tc      (line_tc),
        .frame_start  (frame_start),
        .fetch_req    (fetch_req),
        .fetch_line   (fetch_line),
        .fetch_ack    (fetch_ack),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks a pending request on its fifth sampled cycle.
    initial begin
        auto_ack = 1'b0;
        ack_cnt  = 0;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                auto_ack = 1'b0;
                ack_cnt  = 0;
            end else if (auto_en && fetch_req) begin
                ack_cnt++;
                if (ack_cnt == 5) auto_ack = 1'b1;
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        en           = 1'b0;
        clr_underrun = 1'b0;
        man_ack      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (x !== 11'd0 || y !== 11'd0) begin
            errors++;
            $display("FAIL reset_xy: x=%0d y=%0d expected 0 0", x, y);
        end
        checks++;
        if (de !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("FAIL reset_sync: de=%b hs=%b vs=%b expected 000",
                     de, hsync, vsync);
        end
        checks++;
        if (line_tc !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: tc=%b fs=%b expected 00",
                     line_tc, frame_start);
        end
        checks++;
        if (fetch_req !== 1'b0 || fetch_line !== 11'd0 ||
            underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: req=%b line=%0d ur=%b expected 0 0 0",
                     fetch_req, fetch_line, underrun);
        end
    endtask

    task automatic test_line();
        int hs_n;
        int tc_n;
        logic [10:0] ex;
        logic e;
        hs_n = 0;
        tc_n = 0;
        do_reset();
        auto_en = 1'b1;
        en = 1'b1;
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            ex = 11'(i);
            checks++;
            if (x !== ex || y !== 11'd0) begin
                errors++;
                $display("FAIL line_pos: x=%0d y=%0d expected %0d 0", x, y, ex);
            end
            e = (i >= HS0 && i <= HS1);
            checks++;
            if (hsync !== e) begin
                errors++;
                $display("FAIL line_hsync: x=%0d hsync=%b expected %b", i, hsync, e);
            end
            e = (i < 800);
            checks++;
            if (de !== e) begin
                errors++;
                $display("FAIL line_de: x=%0d de=%b expected %b", i, de, e);
            end
            e = (i == HT - 1);
            checks++;
            if (line_tc !== e) begin
                errors++;
                $display("FAIL line_tc: x=%0d tc=%b expected %b", i, line_tc, e);
            end
            if (hsync === 1'b1) hs_n++;
            if (line_tc === 1'b1) tc_n++;
        end
        checks++;
        if (hs_n != 120 || tc_n != 1) begin
            errors++;
            $display("FAIL line_counts: hsync=%0d tc=%0d expected 120 1", hs_n, tc_n);
        end
    endtask

    task automatic test_frame();
        int px;
        int py;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [10:0] el;
        logic e;
        logic due;
        do_reset();
        auto_en = 1'b1;
        en = 1'b1;
        for (int i = 0; i <= VT * HT; i++) begin
            @(negedge clk);
            px = i % HT;
            py = (i / HT) % VT;
            ex = 11'(px);
            ey = 11'(py);
            checks++;
            if (x !== ex || y !== ey) begin
                errors++;
                $display("FAIL frame_pos: x=%0d y=%0d expected %0d %0d", x, y, ex, ey);
            end
            e = (py >= VS0 && py <= VS1);
            checks++;
            if (vsync !== e) begin
                errors++;
                $display("FAIL frame_vsync: y=%0d vsync=%b expected %b", py, vsync, e);
            end
            e = (px < 800) && (py < VA);
            checks++;
            if (de !== e) begin
                errors++;
                $display("FAIL frame_de: x=%0d y=%0d de=%b expected %b", px, py, de, e);
            end
            checks++;
            if (underrun !== 1'b0) begin
                errors++;
                $display("FAIL frame_underrun: y=%0d ur=%b expected 0", py, underrun);
            end
            if (i > 0) begin
                e = (i == VT * HT);
                checks++;
                if (frame_start !== e) begin
                    errors++;
                    $display("FAIL frame_start: i=%0d fs=%b expected %b", i, frame_start, e);
                end
            end
            if (px == 799) begin
                checks++;
                if (fetch_req !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_req_idle: y=%0d req=%b expected 0", py, fetch_req);
                end
            end
            if (px == 800) begin
                due = (py + 1 < VA) || (py == VT - 1);
                el  = (py == VT - 1) ? 11'd0 : 11'(py + 1);
                checks++;
                if (fetch_req !== due || (due && fetch_line !== el)) begin
                    errors++;
                    $display("FAIL frame_fetch: y=%0d req=%b line=%0d expected %b %0d",
                             py, fetch_req, fetch_line, due, el);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int px;
        int py;
        do_reset();
        auto_en = 1'b1;
        en = 1'b1;
        for (int i = 0; i <= 8 * HT + 801; i++) begin
            @(negedge clk);
            px = i % HT;
            py = i / HT;
            if (py == 5 && px == 0) auto_en = 1'b0;
            if (py == 5 && (px == 800 || px == 1039)) begin
                checks++;
                if (fetch_req !== 1'b1 || fetch_line !== 11'd6 || underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL ur_pending: x=%0d req=%b line=%0d ur=%b expected 1 6 0",
                             px, fetch_req, fetch_line, underrun);
                end
            end
            if (py == 6 && px == 0) begin
                checks++;
                if (fetch_req !== 1'b0 || underrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ur_deadline: req=%b ur=%b expected 0 1", fetch_req, underrun);
                end
                auto_en = 1'b1;
            end
            if (py == 6 && px == 500) begin
                checks++;
                if (underrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ur_sticky: ur=%b expected 1", underrun);
                end
            end
            if (py == 6 && px == 600) clr_underrun = 1'b1;
            if (py == 6 && px == 601) begin
                clr_underrun = 1'b0;
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL ur_clear: ur=%b expected 0", underrun);
                end
            end
            if (py == 7 && px == 0) auto_en = 1'b0;
            if (py == 7 && px == 1039) clr_underrun = 1'b1;
            if (py == 8 && px == 0) begin
                clr_underrun = 1'b0;
                auto_en = 1'b1;
                checks++;
                if (underrun !== 1'b1 || fetch_req !== 1'b0) begin
                    errors++;
                    $display("FAIL ur_set_wins: ur=%b req=%b expected 1 0", underrun, fetch_req);
                end
            end
            if (py == 8 && px == 799) man_ack = 1'b1;
            if (py == 8 && (px == 800 || px == 801)) begin
                man_ack = 1'b0;
                checks++;
                if (fetch_req !== 1'b1 || fetch_line !== 11'd9) begin
                    errors++;
                    $display("FAIL ur_stray_ack: x=%0d req=%b line=%0d expected 1 9",
                             px, fetch_req, fetch_line);
                end
            end
        end
    endtask

    task automatic test_ack_deadline();
        int px;
        int py;
        do_reset();
        auto_en = 1'b1;
        en = 1'b1;
        for (int i = 0; i <= 3 * HT + 10; i++) begin
            @(negedge clk);
            px = i % HT;
            py = i / HT;
            if (py == 2 && px == 0) auto_en = 1'b0;
            if (py == 2 && px == 1039) begin
                checks++;
                if (fetch_req !== 1'b1 || fetch_line !== 11'd3) begin
                    errors++;
                    $display("FAIL ackdl_pending: req=%b line=%0d expected 1 3",
                             fetch_req, fetch_line);
                end
                man_ack = 1'b1;
            end
            if (py == 3 && px == 0) begin
                man_ack = 1'b0;
                auto_en = 1'b1;
            end
            if (py == 3 && px == 10) begin
                checks++;
                if (underrun !== 1'b0 || fetch_req !== 1'b0) begin
                    errors++;
                    $display("FAIL ackdl_no_underrun: ur=%b req=%b expected 0 0",
                             underrun, fetch_req);
                end
            end
        end
    endtask

    task automatic test_stretch();
        int n;
        int hs_n;
        logic [10:0] ex;
        logic [10:0] ey;
        logic e;
        hs_n = 0;
        do_reset();
        auto_en = 1'b1;
        for (int k = 0; k < 3 * HT + 6; k++) begin
            en = (k % 3 == 0);
            @(negedge clk);
            n  = k / 3;
            ex = 11'(n % HT);
            ey = 11'(n / HT);
            checks++;
            if (x !== ex || y !== ey) begin
                errors++;
                $display("FAIL stretch_pos: k=%0d x=%0d y=%0d expected %0d %0d",
                         k, x, y, ex, ey);
            end
            e = (k % 3 == 0) && (n % HT == HT - 1);
            checks++;
            if (line_tc !== e) begin
                errors++;
                $display("FAIL stretch_tc: k=%0d tc=%b expected %b", k, line_tc, e);
            end
            if (k > 0) begin
                checks++;
                if (frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL stretch_fs: k=%0d fs=%b expected 0", k, frame_start);
                end
            end
            if (k < 3 * HT && hsync === 1'b1) hs_n++;
        end
        en = 1'b1;
        checks++;
        if (hs_n != 360) begin
            errors++;
            $display("FAIL stretch_hsync: cycles=%0d expected 360", hs_n);
        end
    endtask

    task automatic test_reset_mid();
        int px;
        int py;
        do_reset();
        auto_en = 1'b1;
        en = 1'b1;
        for (int i = 0; i <= 7 * HT + 900; i++) begin
            @(negedge clk);
            if (i == 7 * HT) auto_en = 1'b0;
        end
        checks++;
        if (x !== 11'd900 || y !== 11'd7 || fetch_req !== 1'b1 || fetch_line !== 11'd8) begin
            errors++;
            $display("FAIL rmid_setup: x=%0d y=%0d req=%b line=%0d expected 900 7 1 8",
                     x, y, fetch_req, fetch_line);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fetch_req !== 1'b0 || x !== 11'd0 || y !== 11'd0 || de !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: req=%b x=%0d y=%0d de=%b expected 0 0 0 0",
                     fetch_req, x, y, de);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 900; i++) begin
            @(negedge clk);
            px = i;
            if (px == 5 || px == 900) begin
                checks++;
                if (underrun !== 1'b0 || x !== 11'(px) || y !== 11'd0) begin
                    errors++;
                    $display("FAIL rmid_line0: x=%0d y=%0d ur=%b expected %0d 0 0",
                             x, y, underrun, px);
                end
            end
            if (px == 5) begin
                checks++;
                if (fetch_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_no_req: req=%b expected 0", fetch_req);
                end
            end
            if (px == 800) begin
                checks++;
                if (fetch_req !== 1'b1 || fetch_line !== 11'd1) begin
                    errors++;
                    $display("FAIL rmid_fetch1: req=%b line=%0d expected 1 1",
                             fetch_req, fetch_line);
                end
            end
        end
        py = 0;
        if (py != 0) errors++;
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        clr_underrun = 1'b0;
        man_ack      = 1'b0;
        auto_en      = 1'b0;
        checks       = 0;
        errors       = 0;
        test_reset();
        test_line();
        test_frame();
        test_underrun();
        test_ack_deadline();
        test_stretch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
